// File: rtl/serial_negate_unit.sv
// Multi-cycle two's-complement pass/negate/abs/negative-abs unit.
// The operand is processed CHUNK bits per cycle, and the +1 is carried between cycles.
module serial_negate_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_inv;
  logic             r_is_min;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_ovf;

  logic             w_inv_new;
  logic             w_last;
  logic             w_ovf;
  logic [CHUNK-1:0] w_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_next_data;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  assign w_last = (r_idx == LAST_IDX);
  assign w_ovf  = r_inv & r_is_min;
  assign w_sum  = {1'b0, w_chunk ^ {CHUNK{r_inv}}} + {{CHUNK{1'b0}}, r_carry};

  // Invert decision for the operand being offered.
  always_comb begin
    w_inv_new = 1'b0;
    case (in_mode)
      2'b00:   w_inv_new = 1'b0;
      2'b01:   w_inv_new = 1'b1;
      2'b10:   w_inv_new = in_data[WIDTH-1];
      2'b11:   w_inv_new = ~in_data[WIDTH-1];
      default: w_inv_new = 1'b0;
    endcase
  end

  // Pick the chunk addressed by r_idx, then write its sum back into the word.
  always_comb begin
    w_chunk = {CHUNK{1'b0}};
    for (int k = 0; k < NCHUNK; k++) begin
      w_chunk = (r_idx == IDXW'(k)) ? r_data[k*CHUNK +: CHUNK] : w_chunk;
    end
  end

  always_comb begin
    w_next_data = r_data;
    for (int k = 0; k < NCHUNK; k++) begin
      w_next_data[k*CHUNK +: CHUNK] = (r_idx == IDXW'(k)) ? w_sum[CHUNK-1:0]
                                                           : r_data[k*CHUNK +: CHUNK];
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = S_BUSY;
        else          w_next_state = S_IDLE;
      end
      S_BUSY: begin
        if (w_last) w_next_state = S_DONE;
        else        w_next_state = S_BUSY;
      end
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
        else           w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Operand capture, per-chunk datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= {WIDTH{1'b0}};
      r_idx      <= {IDXW{1'b0}};
      r_carry    <= 1'b0;
      r_inv      <= 1'b0;
      r_is_min   <= 1'b0;
      r_out_data <= {WIDTH{1'b0}};
      r_out_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data   <= in_data;
            r_inv    <= w_inv_new;
            r_carry  <= w_inv_new;
            r_idx    <= {IDXW{1'b0}};
            r_is_min <= (in_data == MIN);
          end
        end
        S_BUSY: begin
          r_data  <= w_next_data;
          r_carry <= w_sum[CHUNK];
          r_idx   <= w_last ? {IDXW{1'b0}} : r_idx + 1'b1;
          if (w_last) begin
            // Negating MIN wraps back to MIN by itself; only saturation needs a substitute.
            r_out_data <= (w_ovf && SAT) ? MAX : w_next_data;
            r_out_ovf  <= w_ovf;
          end
        end
        S_DONE: begin
          r_out_data <= r_out_data;
        end
        default: begin
          r_idx <= {IDXW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_negate_unit.sv
// Randomised and directed bench for serial_negate_unit; four configurations share one stimulus stream.
module tb_serial_negate_unit;

  localparam int NCH  [4] = '{4, 4, 1, 8};
  localparam bit SATV [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_ready;

  logic [3:0]       w_ir;
  logic [3:0]       w_ov;
  logic [3:0]       w_of;
  logic [3:0][31:0] w_od;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_negate_unit #(.WIDTH(32), .CHUNK(8), .SAT(1'b0)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[0]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(w_ov[0]), .out_ready(out_ready), .out_data(w_od[0]),
    .out_ovf(w_of[0]));
  serial_negate_unit #(.WIDTH(32), .CHUNK(8), .SAT(1'b1)) u_c8s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[1]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(w_ov[1]), .out_ready(out_ready), .out_data(w_od[1]),
    .out_ovf(w_of[1]));
  serial_negate_unit #(.WIDTH(32), .CHUNK(32), .SAT(1'b0)) u_c32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[2]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(w_ov[2]), .out_ready(out_ready), .out_data(w_od[2]),
    .out_ovf(w_of[2]));
  serial_negate_unit #(.WIDTH(32), .CHUNK(4), .SAT(1'b1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[3]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(w_ov[3]), .out_ready(out_ready), .out_data(w_od[3]),
    .out_ovf(w_of[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic, then range-check against 32-bit two's complement.
  function automatic void ref_model(input logic [31:0] a, input logic [1:0] m, input bit sat,
                                    output logic [31:0] r, output logic ovf);
    longint v;
    longint res;
    v = longint'($signed(a));
    case (m)
      2'd0:    res = v;
      2'd1:    res = -v;
      2'd2:    res = (v < 0) ? -v : v;
      default: res = (v > 0) ? -v : v;
    endcase
    ovf = (res > 64'sd2147483647);
    if (ovf && sat) r = 32'h7FFF_FFFF;
    else            r = res[31:0];
  endfunction

  // Called just after the acceptance edge; gathers every instance's result and latency.
  task automatic collect(input logic [31:0] a, input logic [1:0] m);
    int          lat  [4];
    logic [31:0] d    [4];
    logic        of   [4];
    bit          seen [4];
    logic [31:0] er;
    logic        eo;
    int          n;
    bit          all_done;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 1'b0;
      lat[i]  = -1;
      d[i]    = 32'h0;
      of[i]   = 1'b0;
    end
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      for (int i = 0; i < 4; i++) begin
        if (seen[i] && lat[i] == n - 1) check($sformatf("ready_after_hs%0d", i), 32'(w_ir[i]), 32'd1);
        if (!seen[i] && w_ov[i]) begin
          seen[i] = 1'b1;
          lat[i]  = n;
          d[i]    = w_od[i];
          of[i]   = w_of[i];
          check($sformatf("ready_in_done%0d", i), 32'(w_ir[i]), 32'd0);
        end
      end
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) if (!seen[i] || lat[i] == n) all_done = 1'b0;
      if (all_done) break;
    end
    for (int i = 0; i < 4; i++) begin
      ref_model(a, m, SATV[i], er, eo);
      if (!seen[i]) begin
        check($sformatf("timeout%0d", i), 32'd0, 32'd1);
      end else begin
        check($sformatf("latency%0d", i), 32'(lat[i]), 32'(NCH[i]));
        check($sformatf("data%0d a=%h m=%0d", i, a, m), d[i], er);
        check($sformatf("ovf%0d a=%h m=%0d", i, a, m), 32'(of[i]), 32'(eo));
      end
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [1:0] m);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("idle_ready%0d", i), 32'(w_ir[i]), 32'd1);
    in_valid = 1'b1;
    in_data  = a;
    in_mode  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [1:0] m);
    accept(a, m);
    collect(a, m);
  endtask

  logic [31:0] dir_a [10] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_FF85,
                              32'h0000_007B, 32'h0000_007B, 32'hDEAD_BEEF, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000};
  logic [1:0]  dir_m [10] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] spec_a [4] = '{32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic [31:0] er;
    logic        eo;
    logic [31:0] a;
    logic [31:0] b;
    int          wait_n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(w_ir[i]), 32'd0);
      check($sformatf("rst_valid%0d", i), 32'(w_ov[i]), 32'd0);
      check($sformatf("rst_data%0d", i), w_od[i], 32'd0);
      check($sformatf("rst_ovf%0d", i), 32'(w_of[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 10; t++) run_op(dir_a[t], dir_m[t]);

    // Backpressure with a competing operand held on the input.
    out_ready = 1'b0;
    a = 32'h0000_1234;
    b = 32'hFFFF_0F00;
    accept(a, 2'd1);
    wait_n = 0;
    while (w_ov != 4'hF && wait_n < 20) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    check("bp_all_valid", 32'(w_ov), 32'hF);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_mode  = 2'd2;
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        ref_model(a, 2'd1, SATV[i], er, eo);
        check($sformatf("bp_valid%0d", i), 32'(w_ov[i]), 32'd1);
        check($sformatf("bp_data%0d", i), w_od[i], er);
        check($sformatf("bp_ready%0d", i), 32'(w_ir[i]), 32'd0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hs_valid%0d", i), 32'(w_ov[i]), 32'd0);
      check($sformatf("bp_hs_ready%0d", i), 32'(w_ir[i]), 32'd1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("bp_taken%0d", i), 32'(w_ir[i]), 32'd0);
    in_valid = 1'b0;
    in_data  = $urandom;
    collect(b, 2'd2);

    // Asynchronous reset two edges into the operation.
    accept(32'h0000_0F0F, 2'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_valid%0d", i), 32'(w_ov[i]), 32'd0);
      check($sformatf("abort_data%0d", i), w_od[i], 32'd0);
      check($sformatf("abort_ovf%0d", i), 32'(w_of[i]), 32'd0);
      check($sformatf("abort_ready%0d", i), 32'(w_ir[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h0000_0005, 2'd1);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = spec_a[$urandom_range(0, 3)];
      run_op(a, 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_negate_unit.md
Name: serial_negate_unit

Overview:
- Parametrised multi-cycle two's-complement negation / absolute-value unit for the datapath.
- Processes a WIDTH-bit operand CHUNK bits per cycle and carries the +1 between cycles, so the carry chain is CHUNK bits, not WIDTH.
- Supports pass, negate, absolute-value and negative-absolute modes, with an overflow flag and optional saturation.
- Sits between an operand producer and consumer using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- CHUNK, 8, bits processed per cycle; WIDTH must be an exact multiple of CHUNK.
- SAT, 0, 1 = overflowing results saturate to the most positive value; 0 = wrap.
- Derived: NCHUNK = WIDTH/CHUNK; MIN = 1 followed by WIDTH-1 zeros; MAX = 0 followed by WIDTH-1 ones.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  unit can accept an operand
- in_data  in  WIDTH  operand, two's complement
- in_mode  in  2  00 pass, 01 negate, 10 abs, 11 negative-abs (-|a|)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_ovf  out  1  result overflowed (wrapped or saturated)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, out_valid=0, out_data=0, out_ovf=0, chunk index=0, carry=0. in_ready=(state==IDLE)&&!rst, so it reads 0 while rst is high.
- Reset mid-operation aborts the operation. No partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Acceptance happens on a clock edge where in_valid&&in_ready. On acceptance:
  - latch in_data;
  - set inv: pass 0; negate 1; abs = in_data[WIDTH-1]; neg-abs = ~in_data[WIDTH-1];
  - carry = inv; idx = 0;
  - is_min = (in_data==MIN);
  - go to BUSY.
- BUSY, each edge:
  - chunk[idx] = (data chunk[idx] XOR {CHUNK{inv}}) + carry;
  - carry takes the chunk carry-out; idx increments.
  - Chunk 0 is the LSB chunk.
  - After the chunk where idx==NCHUNK-1: go to DONE, out_valid=1.
- Latency: out_valid rises on the NCHUNK-th edge after the acceptance edge (4 edges at defaults).
- Overflow: out_ovf = inv && is_min, i.e. only for negate or abs of MIN. neg-abs of MIN is exact (inv=0), so out_ovf=0.
  - SAT=0: out_data=MIN with out_ovf=1.
  - SAT=1: out_data=MAX with out_ovf=1. The substitution is applied at the BUSY→DONE edge.
- Zero in negate mode: carry propagates through every chunk; result 0, out_ovf=0.
- DONE:
  - out_valid=1; out_data and out_ovf held stable while out_ready=0.
  - in_ready=0, so in_valid is ignored.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. out_data and out_ovf keep their last value.
- No input/output overlap: the earliest next acceptance is the edge after the result handshake. Minimum interval is NCHUNK+2 cycles per operand.
- in_data and in_mode are sampled only at acceptance. Later changes have no effect.
- CHUNK==WIDTH is legal: BUSY lasts exactly one cycle.

Test Plan:
- Defaults; negate 0x00000001, out_ready=1:
  - out_data=0xFFFFFFFF, out_ovf=0;
  - out_valid exactly 4 edges after acceptance;
  - in_ready returns 1 one cycle after the output handshake.
- Negate 0x00000000 and 0x00000100 (cross-chunk carry) → 0x00000000 and 0xFFFFFF00, out_ovf=0.
- Abs and neg-abs:
  - abs 0xFFFFFF85 → 0x0000007B;
  - abs 0x0000007B → 0x0000007B;
  - neg-abs 0x0000007B → 0xFFFFFF85;
  - pass 0xDEADBEEF → 0xDEADBEEF;
  - all with out_ovf=0.
- MIN corner:
  - SAT=0, negate 0x80000000 → 0x80000000, out_ovf=1;
  - SAT=1, negate 0x80000000 → 0x7FFFFFFF, out_ovf=1;
  - SAT=1, abs 0x80000000 → 0x7FFFFFFF, out_ovf=1;
  - neg-abs 0x80000000 → 0x80000000, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with a new operand.
  - out_data stable, in_ready=0, new operand not taken.
  - out_ready=1 completes the handshake; the new operand is accepted on the following edge.
- Reset mid-operation: assert rst asynchronously 2 edges into BUSY.
  - Outputs go to 0 immediately.
  - After release, negate 0x00000005 → 0xFFFFFFFB correctly.
  - Repeat the Test Plan scenarios with CHUNK=32 and with CHUNK=4.
